// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back slice.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    // Result source; also the grant-vector bit index of each producer.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arb.sv
// Two-way round-robin arbiter for the register-file write port.
// rr_q names the source favoured on the next contended cycle.
module regfile_wb_arb
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    src_e rr_q;
    src_e rr_d;

    // Grant selection; the favoured source passes to the loser after a contended grant.
    always_comb begin
        gnt_o = '0;
        rr_d  = rr_q;
        if (!rst) begin
            if (req_i[SRC_ALU] && req_i[SRC_LSU]) begin
                gnt_o[rr_q] = 1'b1;
                rr_d        = (rr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= SRC_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller for the 2R1W integer register file: arbitrates ALU
// and LSU results onto the single registered write port and keeps the
// per-register busy scoreboard used for RAW hazard stalls.
// Optional macro REGFILE_WB_BYPASS_EN adds a combinational forwarding path
// from the write port to the two read ports.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_rd,
    output logic [AW-1:0]    wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             we0,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [AW-1:0]    byp_addr0,
    input  logic [AW-1:0]    byp_addr1,
    input  logic [WIDTH-1:0] raw0,
    input  logic [WIDTH-1:0] raw1,
    output logic [WIDTH-1:0] fwd0,
    output logic [WIDTH-1:0] fwd1,
`endif
    output logic [DEPTH-1:0] busy
);

    logic [1:0]       gnt;
    logic [AW-1:0]    sel_rd;
    logic [WIDTH-1:0] sel_data;
    logic             wr_fire;

    logic             we0_q,      we0_d;
    logic [AW-1:0]    wr_addr0_q, wr_addr0_d;
    logic [WIDTH-1:0] wr_din0_q,  wr_din0_d;
    logic [DEPTH-1:0] busy_q,     busy_d;

    regfile_wb_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({lsu_valid, alu_valid}),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[SRC_ALU];
    assign lsu_ready = gnt[SRC_LSU];

    // Steer the granted source's destination and data.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt[SRC_LSU]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Writes to x0 complete the handshake but never reach the port.
    assign wr_fire = (|gnt) && (sel_rd != '0);

    // Next write-port state; address and data hold when nothing is written.
    always_comb begin
        we0_d      = wr_fire;
        wr_addr0_d = wr_addr0_q;
        wr_din0_d  = wr_din0_q;
        if (wr_fire) begin
            wr_addr0_d = sel_rd;
            wr_din0_d  = sel_data;
        end
    end

    // Scoreboard update: clear on write, set on reservation (set wins), x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (we0_q) begin
            busy_d[wr_addr0_q] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we0_q      <= 1'b0;
            wr_addr0_q <= '0;
            wr_din0_q  <= '0;
            busy_q     <= '0;
        end else begin
            we0_q      <= we0_d;
            wr_addr0_q <= wr_addr0_d;
            wr_din0_q  <= wr_din0_d;
            busy_q     <= busy_d;
        end
    end

    assign we0      = we0_q;
    assign wr_addr0 = wr_addr0_q;
    assign wr_din0  = wr_din0_q;
    assign busy     = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the write on the port for the cycle before it lands in the array.
    always_comb begin
        fwd0 = raw0;
        fwd1 = raw1;
        if (we0_q && (wr_addr0_q == byp_addr0) && (byp_addr0 != '0)) begin
            fwd0 = wr_din0_q;
        end
        if (we0_q && (wr_addr0_q == byp_addr1) && (byp_addr1 != '0)) begin
            fwd1 = wr_din0_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed test for regfile_writeback with hand-computed expectations.
module tb_regfile_writeback;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, lsu_valid, rsv_valid;
    logic             alu_ready, lsu_ready;
    logic [AW-1:0]    alu_rd, lsu_rd, rsv_rd;
    logic [WIDTH-1:0] alu_data, lsu_data;
    logic [AW-1:0]    wr_addr0;
    logic [WIDTH-1:0] wr_din0;
    logic             we0;
    logic [DEPTH-1:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0]    byp_addr0, byp_addr1;
    logic [WIDTH-1:0] raw0, raw1, fwd0, fwd1;
`endif

    int total = 0;
    int bad   = 0;

    regfile_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .wr_addr0  (wr_addr0),
        .wr_din0   (wr_din0),
        .we0       (we0),
`ifdef REGFILE_WB_BYPASS_EN
        .byp_addr0 (byp_addr0),
        .byp_addr1 (byp_addr1),
        .raw0      (raw0),
        .raw1      (raw1),
        .fwd0      (fwd0),
        .fwd1      (fwd1),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rsv_valid = 1'b0; rsv_rd = '0;
`ifdef REGFILE_WB_BYPASS_EN
        byp_addr0 = '0; byp_addr1 = '0; raw0 = '0; raw1 = '0;
`endif
        tick();
        // Readies stay low while in reset
        alu_valid = 1'b1; alu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
        #1;
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("rst_we0",   {31'd0, we0}, 32'd0);
        chk("rst_addr",  {27'd0, wr_addr0}, 32'd0);
        chk("rst_din",   wr_din0, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        rst = 1'b0;
        tick();

        // Single ALU write, one-cycle latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("alu_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu_we0",  {31'd0, we0}, 32'd1);
        chk("alu_addr", {27'd0, wr_addr0}, 32'd5);
        chk("alu_din",  wr_din0, 32'hDEADBEEF);
        tick();
        chk("alu_we0_off", {31'd0, we0}, 32'd0);
        chk("alu_addr_hold", {27'd0, wr_addr0}, 32'd5);
        chk("alu_din_hold", wr_din0, 32'hDEADBEEF);

        // Contended grants alternate ALU, LSU, ALU, LSU
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_0000;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'h3333_0000 + i;
            lsu_data = 32'h4444_0000 + i;
            #1;
            chk("rr_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_we0",  {31'd0, we0}, 32'd1);
            chk("rr_addr", {27'd0, wr_addr0}, (i % 2 == 0) ? 32'd3 : 32'd4);
            chk("rr_din",  wr_din0, (i % 2 == 0) ? (32'h3333_0000 + i) : (32'h4444_0000 + i));
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        chk("rr_idle_we0", {31'd0, we0}, 32'd0);

        // Reservation of x7, then LSU write to x7 clears it
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk("rsv7_set", busy, 32'h0000_0080);
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_7777;
        #1;
        chk("lsu7_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("lsu7_we0",  {31'd0, we0}, 32'd1);
        chk("lsu7_addr", {27'd0, wr_addr0}, 32'd7);
        chk("lsu7_din",  wr_din0, 32'h7777_7777);
        chk("lsu7_busy_still", busy, 32'h0000_0080);
        tick();
        chk("lsu7_busy_clr", busy, 32'd0);

        // Set wins over clear on the same index
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        tick();
        alu_valid = 1'b0;
        chk("sw_we0",  {31'd0, we0}, 32'd1);
        chk("sw_addr", {27'd0, wr_addr0}, 32'd9);
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0;
        chk("sw_busy9", busy, 32'h0000_0200);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("sw_busy_clr", busy, 32'd0);

        // x0 destination: handshake completes, no write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        #1;
        chk("x0_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("x0_we0",  {31'd0, we0}, 32'd0);
        chk("x0_busy", busy, 32'd0);

        // Reserving x0 leaves the scoreboard clear
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        tick();
        rsv_valid = 1'b0;
        chk("rsv0_busy", busy, 32'd0);

`ifdef REGFILE_WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hA5A5A5A5;
        tick();
        alu_valid = 1'b0;
        byp_addr0 = 5'd6; raw0 = 32'h0;
        byp_addr1 = 5'd2; raw1 = 32'h11;
        #1;
        chk("byp_fwd0", fwd0, 32'hA5A5A5A5);
        chk("byp_fwd1", fwd1, 32'h0000_0011);
        tick();
        chk("byp_fwd0_off", fwd0, 32'h0);
`endif

        // Contended grant moves pointer to LSU; reset must restore ALU priority
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hBBBB_0001;
        #1;
        chk("pre_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        chk("pre_rst_we0", {31'd0, we0}, 32'd1);
        rsv_valid = 1'b1; rsv_rd = 5'd12;
        rst = 1'b1;
        #1;
        chk("midrst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        rsv_valid = 1'b0;
        chk("midrst_we0",  {31'd0, we0}, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_addr", {27'd0, wr_addr0}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("post_rst_addr", {27'd0, wr_addr0}, 32'd10);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
